// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: memory-op sizes, controller states and
// small helpers that classify an op and its address alignment.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      MOP_WORD = 2'b00,
      MOP_HALF = 2'b01,
      MOP_NONE = 2'b10,
      MOP_BYTE = 2'b11
   } mop_e;

   typedef enum logic [1:0] {
      MS_IDLE   = 2'b00,
      MS_ACCESS = 2'b01,
      MS_DONE   = 2'b10
   } ms_state_e;

   // A read wins over a simultaneous write, so the read size drives the bus.
   function automatic logic [1:0] eff_op(input logic [1:0] rd_op, input logic [1:0] wr_op);
      return (rd_op != MOP_NONE) ? rd_op : wr_op;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] a_lo);
      return ((op == MOP_HALF) && a_lo[0]) || ((op == MOP_WORD) && (a_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data
// and load lane extraction with sign or zero extension.
module mem_stage_lane_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  i_mem_op,
   input  logic [1:0]  i_rd_op,
   input  logic        i_rd_sign,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_ld_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_st_data,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_lane [4];
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane[gi] = i_ld_data[8*gi +: 8];
      end
   endgenerate

   assign w_byte = w_lane[i_addr_lo];
   assign w_half = i_addr_lo[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

   always_comb begin
      o_be      = 4'b0000;
      o_st_data = '0;
      case (i_mem_op)
         MOP_BYTE: begin
            o_be      = 4'b0001 << i_addr_lo;
            o_st_data = {4{i_st_data[7:0]}};
         end
         MOP_HALF: begin
            o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_st_data = {2{i_st_data[15:0]}};
         end
         MOP_WORD: begin
            o_be      = 4'b1111;
            o_st_data = i_st_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_ld_data = '0;
      case (i_rd_op)
         MOP_BYTE: o_ld_data = {{24{i_rd_sign & w_byte[7]}}, w_byte};
         MOP_HALF: o_ld_data = {{16{i_rd_sign & w_half[15]}}, w_half};
         MOP_WORD: o_ld_data = i_ld_data;
         default:  ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-bus controller with upstream stall.
// Optional misaligned-access exception enabled by defining MEM_MISALIGN_EXC_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       aluresult_i,
   input  logic [31:0]       memWrData_i,
   input  logic [31:0]       pcp4_i,
   input  logic [4:0]        wb_addr_i,
   input  logic              c_RegWrite_i,
   input  logic              c_WBSrc1_i,
   input  logic              c_WBSrc2_i,
   input  logic [1:0]        c_MemRdOp_i,
   input  logic [1:0]        c_MemWrOp_i,
   input  logic              c_MemRdSign_i,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [3:0]        dbus_be,
   output logic [31:0]       dbus_wdata,
   input  logic              dbus_ack,
   input  logic [31:0]       dbus_rdata,
   output logic [31:0]       aluresult_o,
   output logic [31:0]       pcp4_o,
   output logic [31:0]       memRdData_o,
   output logic [4:0]        wb_addr_o,
   output logic              c_RegWrite_o,
   output logic              c_WBSrc1_o,
   output logic              c_WBSrc2_o,
   output logic              e_RegWrite,
   output logic [4:0]        e_WBAddr,
   output logic [31:0]       e_fwd_exmem_data,
   output logic              e_stall,
   output logic              e_memExc,
   output logic [31:0]       e_badAddr
);

   logic [31:0] r_aluresult;
   logic [31:0] r_memWrData;
   logic [31:0] r_pcp4;
   logic [31:0] r_rdata;
   logic [4:0]  r_wb_addr;
   logic        r_RegWrite;
   logic        r_WBSrc1;
   logic        r_WBSrc2;
   logic [1:0]  r_MemRdOp;
   logic [1:0]  r_MemWrOp;
   logic        r_MemRdSign;

   ms_state_e   r_state;
   ms_state_e   w_state_next;

   logic [1:0]  w_op_in;
   logic [1:0]  w_op_reg;
   logic        w_in_misalign;
   logic        w_start_access;
   logic        w_access;
   logic        w_exc;
   logic        w_we;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ld_ext;

   assign w_op_in  = eff_op(c_MemRdOp_i, c_MemWrOp_i);
   assign w_op_reg = eff_op(r_MemRdOp, r_MemWrOp);

`ifdef MEM_MISALIGN_EXC_EN
   // A misaligned op is trapped at load time: it never reaches ACCESS and is
   // reported for the single cycle it sits in the register.
   assign w_in_misalign = is_misaligned(w_op_in, aluresult_i[1:0]);
   assign w_exc         = (r_state == MS_IDLE) && is_misaligned(w_op_reg, r_aluresult[1:0]);
   assign e_memExc      = w_exc;
   assign e_badAddr     = w_exc ? r_aluresult : '0;
`else
   assign w_in_misalign = 1'b0;
   assign w_exc         = 1'b0;
   assign e_memExc      = 1'b0;
   assign e_badAddr     = '0;
`endif

   assign w_start_access = (w_op_in != MOP_NONE) && !w_in_misalign;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= MS_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_access     = 1'b0;
      case (r_state)
         MS_ACCESS: begin
            w_access = 1'b1;
            if (dbus_ack) begin
               w_state_next = MS_DONE;
            end
         end
         default: begin
            w_state_next = w_start_access ? MS_ACCESS : MS_IDLE;
         end
      endcase
   end

   // The EX/MEM register freezes for the whole bus access so addr/be/wdata stay stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_aluresult <= '0;
         r_memWrData <= '0;
         r_pcp4      <= '0;
         r_wb_addr   <= '0;
         r_RegWrite  <= 1'b0;
         r_WBSrc1    <= 1'b0;
         r_WBSrc2    <= 1'b0;
         r_MemRdOp   <= MOP_NONE;
         r_MemWrOp   <= MOP_NONE;
         r_MemRdSign <= 1'b0;
      end else if (r_state != MS_ACCESS) begin
         r_aluresult <= aluresult_i;
         r_memWrData <= memWrData_i;
         r_pcp4      <= pcp4_i;
         r_wb_addr   <= wb_addr_i;
         r_RegWrite  <= c_RegWrite_i;
         r_WBSrc1    <= c_WBSrc1_i;
         r_WBSrc2    <= c_WBSrc2_i;
         r_MemRdOp   <= c_MemRdOp_i;
         r_MemWrOp   <= c_MemWrOp_i;
         r_MemRdSign <= c_MemRdSign_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata <= '0;
      end else if ((r_state == MS_ACCESS) && dbus_ack) begin
         r_rdata <= dbus_rdata;
      end
   end

   mem_stage_lane_align u_lane_align (
      .i_mem_op  (w_op_reg),
      .i_rd_op   (r_MemRdOp),
      .i_rd_sign (r_MemRdSign),
      .i_addr_lo (r_aluresult[1:0]),
      .i_st_data (r_memWrData),
      .i_ld_data (r_rdata),
      .o_be      (w_be),
      .o_st_data (w_wdata),
      .o_ld_data (w_ld_ext)
   );

   // A write alongside a read is dropped; only pure stores assert the write strobe.
   assign w_we = w_access && (r_MemRdOp == MOP_NONE) && (r_MemWrOp != MOP_NONE);

   assign dbus_req   = w_access;
   assign dbus_we    = w_we;
   assign dbus_addr  = w_access ? r_aluresult[ADDR_W-1:0] : '0;
   assign dbus_be    = w_access ? w_be : 4'b0000;
   assign dbus_wdata = w_we ? w_wdata : '0;

   assign aluresult_o  = r_aluresult;
   assign pcp4_o       = r_pcp4;
   assign memRdData_o  = w_ld_ext;
   assign wb_addr_o    = r_wb_addr;
   assign c_RegWrite_o = r_RegWrite && !w_access && !w_exc;
   assign c_WBSrc1_o   = r_WBSrc1;
   assign c_WBSrc2_o   = r_WBSrc2;

   assign e_RegWrite       = r_RegWrite;
   assign e_WBAddr         = r_wb_addr;
   assign e_fwd_exmem_data = r_aluresult;
   assign e_stall          = w_access;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed + random ops, bus responder with
// random latency, independent arithmetic reference model (honours MEM_MISALIGN_EXC_EN).
module tb_mem_stage;

   localparam logic [1:0] OP_W = 2'd0;
   localparam logic [1:0] OP_H = 2'd1;
   localparam logic [1:0] OP_N = 2'd2;
   localparam logic [1:0] OP_B = 2'd3;
`ifdef MEM_MISALIGN_EXC_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] aluresult_i, memWrData_i, pcp4_i;
   logic [4:0]  wb_addr_i;
   logic        c_RegWrite_i, c_WBSrc1_i, c_WBSrc2_i, c_MemRdSign_i;
   logic [1:0]  c_MemRdOp_i, c_MemWrOp_i;
   logic        dbus_req, dbus_we, dbus_ack;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be;
   logic [31:0] aluresult_o, pcp4_o, memRdData_o, e_fwd_exmem_data, e_badAddr;
   logic [4:0]  wb_addr_o, e_WBAddr;
   logic        c_RegWrite_o, c_WBSrc1_o, c_WBSrc2_o, e_RegWrite, e_stall, e_memExc;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .reset_n(reset_n),
      .aluresult_i(aluresult_i), .memWrData_i(memWrData_i), .pcp4_i(pcp4_i),
      .wb_addr_i(wb_addr_i), .c_RegWrite_i(c_RegWrite_i),
      .c_WBSrc1_i(c_WBSrc1_i), .c_WBSrc2_i(c_WBSrc2_i),
      .c_MemRdOp_i(c_MemRdOp_i), .c_MemWrOp_i(c_MemWrOp_i), .c_MemRdSign_i(c_MemRdSign_i),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
      .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
      .aluresult_o(aluresult_o), .pcp4_o(pcp4_o), .memRdData_o(memRdData_o),
      .wb_addr_o(wb_addr_o), .c_RegWrite_o(c_RegWrite_o),
      .c_WBSrc1_o(c_WBSrc1_o), .c_WBSrc2_o(c_WBSrc2_o),
      .e_RegWrite(e_RegWrite), .e_WBAddr(e_WBAddr), .e_fwd_exmem_data(e_fwd_exmem_data),
      .e_stall(e_stall), .e_memExc(e_memExc), .e_badAddr(e_badAddr)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      int          lat;
      logic        rw;
      logic [4:0]  wa;
      logic        chk_be;
   } bus_exp_t;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
   } rsp_t;

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [31:0] ld;
      logic        is_ld;
      logic        s1;
      logic        s2;
   } wb_exp_t;

   bus_exp_t    bus_q[$];
   rsp_t        rsp_q[$];
   wb_exp_t     wb_q[$];
   logic [31:0] exc_q[$];

   int   total = 0;
   int   bad   = 0;
   logic bus_manual = 1'b0;
   int   req_cycles = 0;
   logic in_acc = 1'b0;
   int   cur_lat = 0;
   logic [31:0] cur_rdata = '0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [1:0] op);
      case (op)
         OP_W:    return 4;
         OP_H:    return 2;
         OP_B:    return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int lane_off(input logic [1:0] op, input logic [31:0] a);
      int b;
      b = int'(a % 32'd4);
      if (op == OP_B) return b;
      if (op == OP_H) return (b / 2) * 2;
      return 0;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] op, input logic [31:0] d);
      logic [31:0] w;
      int sz;
      w  = '0;
      sz = op_size(op);
      for (int i = 0; i < 4; i++) w |= ((d >> (8 * (i % sz))) & 32'hFF) << (8 * i);
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] rdat, input logic sgn);
      logic [31:0] mask, v;
      int sz;
      sz   = op_size(op);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = (rdat >> (8 * lane_off(op, a))) & mask;
      if (sgn && sz < 4 && v[8*sz-1]) v |= ~mask;
      return v;
   endfunction

   function automatic logic misaligned(input logic [1:0] op, input logic [31:0] a);
      return ((op == OP_H) && (a % 32'd2 != 0)) || ((op == OP_W) && (a % 32'd4 != 0));
   endfunction

   // ---------------- stimulus ----------------
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rd,
                        input logic [1:0] wr, input logic sgn, input logic rw,
                        input int lat, input logic [31:0] rdat);
      logic [1:0] op;
      bus_exp_t   b;
      rsp_t       r;
      wb_exp_t    w;
      int         be_i;
      logic [4:0] wa;
      logic [31:0] pc;
      logic s1, s2;
      wa = 5'($urandom);
      pc = $urandom;
      s1 = 1'($urandom);
      s2 = 1'($urandom);
      op = (rd != OP_N) ? rd : wr;
      if (EXC_EN && op != OP_N && misaligned(op, a)) begin
         exc_q.push_back(a);
      end else begin
         if (op != OP_N) begin
            be_i     = ((1 << op_size(op)) - 1) << lane_off(op, a);
            b.addr   = a;
            b.be     = be_i[3:0];
            b.we     = (rd == OP_N);
            b.wdata  = model_wdata(op, d);
            b.lat    = lat;
            b.rw     = rw;
            b.wa     = wa;
            b.chk_be = b.we || (op == OP_W);
            bus_q.push_back(b);
            r.lat   = lat;
            r.rdata = rdat;
            rsp_q.push_back(r);
         end
         if (rw) begin
            w.wa    = wa;
            w.alu   = a;
            w.pc    = pc;
            w.is_ld = (rd != OP_N);
            w.ld    = (rd != OP_N) ? model_load(rd, a, rdat, sgn) : 32'h0;
            w.s1    = s1;
            w.s2    = s2;
            wb_q.push_back(w);
         end
      end
      aluresult_i   = a;
      memWrData_i   = d;
      pcp4_i        = pc;
      wb_addr_i     = wa;
      c_RegWrite_i  = rw;
      c_WBSrc1_i    = s1;
      c_WBSrc2_i    = s2;
      c_MemRdOp_i   = rd;
      c_MemWrOp_i   = wr;
      c_MemRdSign_i = sgn;
      @(negedge clk);
      for (int n = 0; e_stall && n < 200; n++) @(negedge clk);
      if (e_stall) chk1("issue_stall_timeout", e_stall, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      issue(32'h0, 32'h0, OP_N, OP_N, 1'b0, 1'b0, 0, 32'h0);
   endtask

   task automatic drain(input string tag);
      bubble();
      for (int k = 0; k < 100 && (bus_q.size() + wb_q.size() + exc_q.size()) != 0; k++)
         @(posedge clk);
      #1;
      chk32({tag, "_bus_q_empty"}, 32'(bus_q.size()), 32'd0);
      chk32({tag, "_wb_q_empty"}, 32'(wb_q.size()), 32'd0);
      chk32({tag, "_exc_q_empty"}, 32'(exc_q.size()), 32'd0);
   endtask

   // ---------------- bus responder ----------------
   initial begin
      dbus_ack   = 1'b0;
      dbus_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!bus_manual) begin
            dbus_ack   = 1'b0;
            dbus_rdata = $urandom;
            if (!dbus_req) begin
               in_acc = 1'b0;
            end else begin
               if (!in_acc) begin
                  chk1("rsp_available", rsp_q.size() != 0, 1'b1);
                  if (rsp_q.size() != 0) begin
                     cur_lat   = rsp_q[0].lat;
                     cur_rdata = rsp_q[0].rdata;
                     void'(rsp_q.pop_front());
                  end else begin
                     cur_lat   = 0;
                     cur_rdata = '0;
                  end
                  in_acc = 1'b1;
               end
               if (cur_lat == 0) begin
                  dbus_ack   = 1'b1;
                  dbus_rdata = cur_rdata;
                  in_acc     = 1'b0;
               end else begin
                  cur_lat--;
               end
            end
         end
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin : bus_mon
      bus_exp_t b;
      if (reset_n && !bus_manual && dbus_req) begin
         if (bus_q.size() == 0) begin
            chk1("bus_unexpected_req", dbus_req, 1'b0);
         end else begin
            b = bus_q[0];
            req_cycles++;
            chk32("bus_addr", dbus_addr, b.addr);
            chk1("bus_we", dbus_we, b.we);
            if (b.chk_be) chk32("bus_be", 32'(dbus_be), 32'(b.be));
            if (b.we) chk32("bus_wdata", dbus_wdata, b.wdata);
            chk1("bus_stall", e_stall, 1'b1);
            chk1("bus_wb_bubble", c_RegWrite_o, 1'b0);
            chk1("bus_e_regwrite", e_RegWrite, b.rw);
            chk32("bus_e_wbaddr", 32'(e_WBAddr), 32'(b.wa));
            if (dbus_ack) begin
               chk32("bus_req_cycles", 32'(req_cycles), 32'(b.lat + 1));
               $display("bus addr=%08h be=%b we=%b wdata=%08h cycles=%0d",
                        dbus_addr, dbus_be, dbus_we, dbus_wdata, req_cycles);
               void'(bus_q.pop_front());
               req_cycles = 0;
            end
         end
      end
   end

   always @(negedge clk) begin : wb_mon
      wb_exp_t     w;
      logic [31:0] ea;
      if (reset_n && !bus_manual && c_RegWrite_o) begin
         if (wb_q.size() == 0) begin
            chk1("wb_unexpected", c_RegWrite_o, 1'b0);
         end else begin
            w = wb_q.pop_front();
            chk32("wb_addr", 32'(wb_addr_o), 32'(w.wa));
            chk32("wb_alu", aluresult_o, w.alu);
            chk32("wb_fwd", e_fwd_exmem_data, w.alu);
            chk32("wb_pcp4", pcp4_o, w.pc);
            chk32("wb_e_wbaddr", 32'(e_WBAddr), 32'(w.wa));
            chk1("wb_e_regwrite", e_RegWrite, 1'b1);
            chk1("wb_src1", c_WBSrc1_o, w.s1);
            chk1("wb_src2", c_WBSrc2_o, w.s2);
            chk1("wb_no_stall", e_stall, 1'b0);
            chk32("wb_badaddr_zero", e_badAddr, 32'h0);
            if (w.is_ld) chk32("wb_load_data", memRdData_o, w.ld);
            $display("wb r%0d alu=%08h rd=%08h load=%0d", wb_addr_o, aluresult_o, memRdData_o, w.is_ld);
         end
      end
      if (reset_n && !bus_manual && e_memExc) begin
         if (exc_q.size() == 0) begin
            chk1("exc_unexpected", e_memExc, 1'b0);
         end else begin
            ea = exc_q.pop_front();
            chk32("exc_badaddr", e_badAddr, ea);
            chk1("exc_no_wb", c_RegWrite_o, 1'b0);
            chk1("exc_no_req", dbus_req, 1'b0);
            $display("exc badAddr=%08h", e_badAddr);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0] op, sz_ops [3];
      int kind;
      sz_ops[0] = OP_W;
      sz_ops[1] = OP_H;
      sz_ops[2] = OP_B;
      reset_n       = 1'b0;
      aluresult_i   = '0;
      memWrData_i   = '0;
      pcp4_i        = '0;
      wb_addr_i     = '0;
      c_RegWrite_i  = 1'b0;
      c_WBSrc1_i    = 1'b0;
      c_WBSrc2_i    = 1'b0;
      c_MemRdOp_i   = OP_N;
      c_MemWrOp_i   = OP_N;
      c_MemRdSign_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_req", dbus_req, 1'b0);
      chk1("rst_stall", e_stall, 1'b0);
      chk1("rst_regwrite", c_RegWrite_o, 1'b0);
      chk32("rst_alu", aluresult_o, 32'h0);
      chk32("rst_rddata", memRdData_o, 32'h0);
      chk32("rst_fwd", e_fwd_exmem_data, 32'h0);
      chk32("rst_be", 32'(dbus_be), 32'h0);
      chk1("rst_memexc", e_memExc, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases
      issue(32'h100, 32'hDEADBEEF, OP_N, OP_W, 1'b0, 1'b0, 3, 32'h0);      // SW, 3-cycle ack delay
      issue(32'h103, 32'h0, OP_B, OP_N, 1'b1, 1'b1, 0, 32'h80112233);      // LB signed
      issue(32'h102, 32'h0, OP_H, OP_N, 1'b0, 1'b1, 1, 32'h9ABC0000);      // LHU
      issue(32'h102, 32'h00001234, OP_N, OP_H, 1'b0, 1'b0, 0, 32'h0);      // SH
      issue(32'h55, 32'h0, OP_N, OP_N, 1'b0, 1'b1, 0, 32'h0);              // ADD
      issue(32'h200, 32'h0, OP_W, OP_N, 1'b0, 1'b1, 2, 32'hA5A5_0F0F);     // LW back-to-back
      issue(32'h101, 32'h0, OP_W, OP_N, 1'b0, 1'b1, 1, 32'h11223344);      // LW misaligned
      issue(32'h204, 32'h77, OP_B, OP_W, 1'b1, 1'b1, 0, 32'h000000F0);     // read wins over write
      drain("directed");

      // Random phase
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         op   = sz_ops[$urandom_range(0, 2)];
         if (kind <= 2)
            issue($urandom, $urandom, OP_N, OP_N, 1'b0, 1'b1, 0, 32'h0);
         else if (kind == 3)
            bubble();
         else if (kind <= 6)
            issue($urandom, $urandom, op, OP_N, 1'($urandom), 1'b1, $urandom_range(0, 3), $urandom);
         else if (kind <= 8)
            issue($urandom, $urandom, OP_N, op, 1'b0, 1'b0, $urandom_range(0, 3), 32'h0);
         else
            issue($urandom, $urandom, op, sz_ops[$urandom_range(0, 2)], 1'($urandom), 1'b1,
                  $urandom_range(0, 3), $urandom);
      end
      drain("random");

      // Reset during a pending access; a late ack must be ignored
      bus_manual    = 1'b1;
      aluresult_i   = 32'h300;
      wb_addr_i     = 5'd7;
      c_RegWrite_i  = 1'b1;
      c_MemRdOp_i   = OP_W;
      c_MemWrOp_i   = OP_N;
      @(posedge clk);
      #1;
      chk1("rst_mid_req_before", dbus_req, 1'b1);
      c_RegWrite_i = 1'b0;
      c_MemRdOp_i  = OP_N;
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk1("rst_mid_req_drop", dbus_req, 1'b0);
      chk1("rst_mid_stall_drop", e_stall, 1'b0);
      dbus_ack   = 1'b1;
      dbus_rdata = 32'hCAFEF00D;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk1("rst_mid_ack_ignored_req", dbus_req, 1'b0);
         chk1("rst_mid_no_wb", c_RegWrite_o, 1'b0);
         chk1("rst_mid_no_stall", e_stall, 1'b0);
      end
      dbus_ack = 1'b0;
      @(posedge clk);
      #1;
      bus_manual = 1'b0;

      issue(32'h400, 32'h0, OP_H, OP_N, 1'b1, 1'b1, 1, 32'h0000_8001);     // recovery load
      drain("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
